tx_frame_controller: RTL and testbench
======================================

TX_FRAME_CONTROLLER -- requirements
Module: tx_frame_controller

Interface
REQ-001 SHALL have parameter CRC_POLY, default 8'h07: CRC-8 generator polynomial x^8+x^2+x+1, normal form.
REQ-002 SHALL have parameter CRC_INIT, default 8'h00: CRC register seed loaded at frame start.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  transmit request, level-sampled each cycle.
REQ-006 SHALL have port tx_packet  input  136  packet image: [135:128] header (dest[7:6], src[5:4], length[3:0]), [127:0] payload bytes MSB-first.
REQ-007 SHALL have port flag_status  input  2  [1] header done, [0] data done.
REQ-008 SHALL have port test_mode  input  1  CRC error-injection request.
REQ-009 SHALL have port tx_data  output  8  serialized frame byte.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  downstream accepts byte.
REQ-012 SHALL have port tx_last  output  1  current byte is the CRC byte.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the CRC byte is accepted.
REQ-015 SHALL have port err_start  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 SHALL implement FSM states IDLE, HDR, PAY, CRC, DONE.
REQ-017 IDLE + start + flag_status==2'b11 SHALL capture tx_packet, test_mode and length L=tx_packet[131:128] into shadow registers, load CRC_INIT, and enter HDR next cycle.
REQ-018 IDLE + start + flag_status!=2'b11 SHALL pulse err_start for 1 cycle and remain in IDLE.
REQ-019 start outside IDLE SHALL be ignored; no err_start, shadow registers unchanged.
REQ-020 A byte transfers only on a cycle with tx_valid&&tx_ready; tx_data and tx_last SHALL hold stable while tx_valid&&!tx_ready.
REQ-021 HDR SHALL present the header byte; on transfer, go to PAY if L>0, else to CRC.
REQ-022 PAY SHALL present payload byte k (k=0..L-1) from bits [127-8k:120-8k]; after transfer of byte L-1, go to CRC.
REQ-023 The CRC register SHALL update on each transferred header/payload byte: MSB-first, no reflection, no final XOR.
REQ-024 CRC SHALL present the CRC register value with tx_last=1; on transfer go to DONE.
REQ-025 DONE SHALL assert done for exactly 1 cycle, then return to IDLE; start in DONE is ignored.
REQ-026 tx_valid SHALL be high exactly in HDR, PAY and CRC; tx_data=0 and tx_last=0 otherwise.
REQ-027 Latency: start accepted at cycle N gives header valid at N+1; with tx_ready held high, frame occupies N+1..N+L+2 and done pulses at N+L+3.
REQ-028 L=0 SHALL produce a 2-byte frame (header, CRC); L=15 SHALL send bytes 0..14, never bits [7:0].

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, CRC register=CRC_INIT, and tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, err_start=0, including mid-frame; no partial-frame resume.
REQ-030 After rst_n deasserts, the first start SHALL be sampled at the next rising edge.

Configuration
REQ-031 With TX_CRC_INJECT_EN defined, the transmitted CRC byte SHALL be the CRC register XOR 8'h01 when the captured test_mode=1.
REQ-032 Without TX_CRC_INJECT_EN, test_mode SHALL be ignored and the CRC byte always correct.

Structure
REQ-033 Package tx_pkg SHALL hold the FSM state encoding, header field bit positions, packet width 136, and the default CRC_POLY/CRC_INIT constants.
REQ-034 Sub-module crc8_update (combinational: crc_in, byte_in -> crc_out, parameterized by CRC_POLY) SHALL compute the per-byte CRC step.

Verification
REQ-035 flags=11, packet header 0x40 (L=0), tx_ready=1, start -> bytes 0x40, 0xC7 (tx_last on 0xC7), done 1 cycle later.
REQ-036 header 0x41, payload byte0 0xAA, tx_ready=1 -> bytes 0x41, 0xAA, 0x11; done at N+4.
REQ-037 TX_CRC_INJECT_EN defined, test_mode=1, header 0x40 -> bytes 0x40, 0xC6; same stimulus without the macro -> 0x40, 0xC7.
REQ-038 L=2, tx_ready low 3 cycles while payload byte 1 is presented -> tx_data/tx_valid stable, no byte lost or duplicated, CRC unchanged.
REQ-039 flags=10, start -> err_start one pulse, busy stays 0; start pulsed mid-frame -> ignored.
REQ-040 rst_n low during PAY -> all outputs 0 immediately; after release, a new start sends a full correct frame.

Source files
------------

// File: rtl/tx_pkg.sv
// tx_pkg: shared definitions for the TX frame controller.
//   - FSM state encoding (tx_state_e)
//   - tx_packet layout: width, header field bit positions, payload width
//   - default CRC-8 generator polynomial and seed
// Optional feature macro used by the top: TX_CRC_INJECT_EN.
package tx_pkg;

  localparam int PKT_W    = 136;
  localparam int PAY_W    = 128;

  // Header byte lives in the top 8 bits of the packet image.
  localparam int HDR_MSB  = 135;
  localparam int HDR_LSB  = 128;
  localparam int DEST_MSB = 135;
  localparam int DEST_LSB = 134;
  localparam int SRC_MSB  = 133;
  localparam int SRC_LSB  = 132;
  localparam int LEN_MSB  = 131;
  localparam int LEN_LSB  = 128;

  localparam logic [7:0] DEF_CRC_POLY = 8'h07;  // x^8+x^2+x+1
  localparam logic [7:0] DEF_CRC_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_CRC  = 3'd3,
    ST_DONE = 3'd4
  } tx_state_e;

endpackage

// File: rtl/crc8_update.sv
// crc8_update: one combinational CRC-8 step over a full byte.
//   MSB-first, no reflection, no final XOR.
// Ports:
//   crc_in  [7:0] current CRC register
//   byte_in [7:0] byte being absorbed
//   crc_out [7:0] CRC register after absorbing byte_in
module crc8_update
  import tx_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = DEF_CRC_POLY
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] w_c;

  always_comb begin
    w_c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[7] ? ((w_c << 1) ^ CRC_POLY) : (w_c << 1);
    end
    crc_out = w_c;
  end

endmodule

// File: rtl/tx_frame_controller.sv
// tx_frame_controller: serializes a captured packet as
//   header byte, L payload bytes (L = header[3:0]), CRC-8 byte.
// Optional feature: define TX_CRC_INJECT_EN to let a captured test_mode=1
// flip bit 0 of the transmitted CRC byte (error injection).
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               transmit request, level-sampled
//   tx_packet [135:0]   header + 16 payload bytes, MSB-first
//   flag_status [1:0]   both bits must be set for start to be accepted
//   test_mode           CRC error-injection request
//   tx_data/tx_valid/tx_ready/tx_last  byte stream out
//   busy, done, err_start               status
// Handshake: a byte moves only on a cycle where tx_valid && tx_ready; while
// tx_valid && !tx_ready, tx_data and tx_last hold their value.
module tx_frame_controller
  import tx_pkg::*;
#(
  parameter logic [7:0] CRC_POLY = DEF_CRC_POLY,
  parameter logic [7:0] CRC_INIT = DEF_CRC_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PKT_W-1:0] tx_packet,
  input  logic [1:0]       flag_status,
  input  logic             test_mode,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             busy,
  output logic             done,
  output logic             err_start
);

  tx_state_e        r_state;
  logic [PAY_W-1:0] r_pay;      // top byte is always the next payload byte
  logic [3:0]       r_len;
  logic [3:0]       r_cnt;      // payload bytes already transferred
  logic             r_tm;
  logic [7:0]       r_crc;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_tx_last;
  logic             r_busy;
  logic             r_done;
  logic             r_err_start;

  logic             w_xfer;
  logic [7:0]       w_crc_next;
  logic [7:0]       w_crc_byte;

  assign w_xfer = r_tx_valid & tx_ready;

  // CRC including the byte currently on tx_data (header/payload states only).
  crc8_update #(.CRC_POLY(CRC_POLY)) u_crc (
    .crc_in  (r_crc),
    .byte_in (r_tx_data),
    .crc_out (w_crc_next)
  );

`ifdef TX_CRC_INJECT_EN
  assign w_crc_byte = w_crc_next ^ {7'b0, r_tm};
`else
  logic w_unused_tm;
  assign w_unused_tm = r_tm;
  assign w_crc_byte  = w_crc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pay       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_tm        <= 1'b0;
      r_crc       <= CRC_INIT;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_start <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (flag_status == 2'b11) begin
              r_pay      <= tx_packet[PAY_W-1:0];
              r_len      <= tx_packet[LEN_MSB:LEN_LSB];
              r_tm       <= test_mode;
              r_crc      <= CRC_INIT;
              r_tx_data  <= tx_packet[HDR_MSB:HDR_LSB];
              r_tx_valid <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_HDR;
            end else begin
              r_err_start <= 1'b1;
            end
          end
        end
        ST_HDR, ST_PAY: begin
          if (w_xfer) begin
            r_crc <= w_crc_next;
            // Last header/payload byte: next byte is the CRC of everything sent.
            if ((r_state == ST_HDR && r_len == 4'd0) ||
                (r_state == ST_PAY && r_cnt == r_len - 4'd1)) begin
              r_tx_data <= w_crc_byte;
              r_tx_last <= 1'b1;
              r_state   <= ST_CRC;
            end else begin
              r_tx_data <= r_pay[PAY_W-1 -: 8];
              r_pay     <= r_pay << 8;
              r_cnt     <= (r_state == ST_HDR) ? 4'd0 : r_cnt + 4'd1;
              r_state   <= ST_PAY;
            end
          end
        end
        ST_CRC: begin
          if (w_xfer) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_last   = r_tx_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_start = r_err_start;

endmodule

// File: tb/tb_tx_frame_controller.sv
// tb_tx_frame_controller: self-checking bench for tx_frame_controller.
// Reference model builds the expected byte stream from the packet image and
// computes the CRC by polynomial long division over the message bit string.
module tb_tx_frame_controller;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [135:0] tx_packet = '0;
  logic [1:0]   flag_status = 2'b00;
  logic         test_mode = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         tx_last;
  logic         busy;
  logic         done;
  logic         err_start;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  tx_frame_controller #(.CRC_POLY(CRC_POLY), .CRC_INIT(CRC_INIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .tx_packet   (tx_packet),
    .flag_status (flag_status),
    .test_mode   (test_mode),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .busy        (busy),
    .done        (done),
    .err_start   (err_start)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
    logic [8:0] g;
    bit         b[$];
    logic [7:0] m;
    logic [7:0] r;
    g = {1'b1, CRC_POLY};
    foreach (msg[i]) begin
      m = (i == 0) ? (msg[i] ^ CRC_INIT) : msg[i];
      for (int j = 7; j >= 0; j--) b.push_back(m[j]);
    end
    for (int j = 0; j < 8; j++) b.push_back(1'b0);
    for (int i = 0; i + 8 < b.size(); i++) begin
      if (b[i]) begin
        for (int j = 0; j < 9; j++) b[i+j] = b[i+j] ^ g[8-j];
      end
    end
    for (int j = 0; j < 8; j++) r[7-j] = b[b.size()-8+j];
    return r;
  endfunction

  task automatic build_expected(input logic [135:0] pkt, input logic tm);
    logic [7:0] msg[$];
    logic [7:0] c;
    int len;
    len = int'(pkt[131:128]);
    msg.push_back(pkt[135:128]);
    for (int k = 0; k < len; k++) msg.push_back(pkt[127-8*k -: 8]);
    c = ref_crc(msg);
`ifdef TX_CRC_INJECT_EN
    c = c ^ {7'b0, tm};
`else
    if (tm) c = c;
`endif
    exp_q = msg;
    exp_q.push_back(c);
  endtask

  task automatic rand_pkt(output logic [135:0] pkt);
    pkt = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pick_ready(input int sent, input int stall_at, input int pct, inout int stalls);
    if (stall_at == sent && stalls < 3) begin
      tx_ready = 1'b0;
      stalls++;
    end else begin
      tx_ready = ($urandom_range(0, 99) >= pct);
    end
  endtask

  task automatic disturb_inputs(input bit disturb);
    logic [135:0] p;
    if (disturb) begin
      rand_pkt(p);
      start       = $urandom_range(0, 1);
      tx_packet   = p;
      test_mode   = $urandom_range(0, 1);
      flag_status = 2'b11;
    end else begin
      start = 1'b0;
    end
  endtask

  // ---------------- driver: one complete frame ----------------
  task automatic send_frame(input logic [135:0] pkt, input logic tm, input int pct,
                            input int stall_at, input bit disturb, output logic [7:0] crc_seen);
    int len, sent, stalls, cyc;
    logic held, held_last;
    logic [7:0] held_data, e;
    len = int'(pkt[131:128]);
    build_expected(pkt, tm);
    sent = 0; stalls = 0; cyc = 0; held = 1'b0; held_data = '0; held_last = 1'b0;
    crc_seen = '0;
    @(posedge clk); #1;
    start = 1'b1; flag_status = 2'b11; tx_packet = pkt; test_mode = tm;
    pick_ready(sent, stall_at, pct, stalls);
    @(posedge clk); #1;
    disturb_inputs(disturb);
    pick_ready(sent, stall_at, pct, stalls);
    cyc = 1;
    while (exp_q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      chk("frame_valid", tx_valid, 1);
      chk("frame_busy", busy, 1);
      chk("frame_no_err", err_start, 0);
      if (held) begin
        chk("hold_data", tx_data, held_data);
        chk("hold_last", tx_last, held_last);
      end
      if (tx_ready) begin
        e = exp_q.pop_front();
        chk("tx_data", tx_data, e);
        chk("tx_last", tx_last, exp_q.size() == 0);
        crc_seen = tx_data;
        sent++;
        held = 1'b0;
      end else begin
        held = 1'b1; held_data = tx_data; held_last = tx_last;
      end
      @(posedge clk); #1;
      disturb_inputs(disturb);
      pick_ready(sent, stall_at, pct, stalls);
      cyc++;
    end
    chk("frame_complete", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_valid", tx_valid, 0);
    chk("done_data", tx_data, 0);
    chk("done_last", tx_last, 0);
    chk("done_busy", busy, 1);
    if (pct == 0 && stall_at < 0) chk("latency", cyc, len + 3);
    @(posedge clk); #1;
    start = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err", err_start, 0);
    chk("idle_valid", tx_valid, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [135:0] pkt;
    logic         tm;
    logic [7:0]   exp_crc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0]   crc_seen;
    logic [135:0] p;
    logic [1:0]   bad_flags[3];

    vecs[0] = '{pkt: {8'h40, 128'h0},          tm: 1'b0, exp_crc: 8'hC7};
    vecs[1] = '{pkt: {8'h41, 8'hAA, 120'h0},   tm: 1'b0, exp_crc: 8'h11};
`ifdef TX_CRC_INJECT_EN
    vecs[2] = '{pkt: {8'h40, 128'h0},          tm: 1'b1, exp_crc: 8'hC6};
`else
    vecs[2] = '{pkt: {8'h40, 128'h0},          tm: 1'b1, exp_crc: 8'hC7};
`endif
    vecs[3] = '{pkt: {8'h80, 128'h0},          tm: 1'b0, exp_crc: 8'h89};
    vecs[4] = '{pkt: {8'h00, 128'h0},          tm: 1'b0, exp_crc: 8'h00};
    bad_flags[0] = 2'b10; bad_flags[1] = 2'b01; bad_flags[2] = 2'b00;

    // ---- reset ----
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_start, 0);
    rst_n = 1'b1;

    // ---- directed table ----
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].pkt, vecs[i].tm, 0, -1, 1'b0, crc_seen);
      chk($sformatf("vec%0d_crc", i), crc_seen, vecs[i].exp_crc);
    end

    // ---- rejected start ----
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rand_pkt(p);
      start = 1'b1; flag_status = bad_flags[i]; tx_packet = p;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("err_pulse_f%0d", i), err_start, 1);
      chk($sformatf("err_busy_f%0d", i), busy, 0);
      chk($sformatf("err_valid_f%0d", i), tx_valid, 0);
      @(negedge clk);
      chk($sformatf("err_clear_f%0d", i), err_start, 0);
      chk($sformatf("err_busy2_f%0d", i), busy, 0);
    end

    // ---- L=2, ready low 3 cycles while payload byte 1 is presented ----
    rand_pkt(p);
    p[135:128] = 8'h02;
    send_frame(p, 1'b0, 0, 2, 1'b0, crc_seen);

    // ---- L=15 boundary, start toggled throughout the frame ----
    rand_pkt(p);
    p[135:128] = 8'hCF;
    send_frame(p, 1'b0, 0, -1, 1'b1, crc_seen);

    // ---- reset during payload ----
    @(posedge clk); #1;
    rand_pkt(p);
    p[135:128] = 8'h05;
    start = 1'b1; flag_status = 2'b11; tx_packet = p; test_mode = 1'b0; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("mid_busy", busy, 1);
    chk("mid_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_last", tx_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(p, 1'b0, 0, -1, 1'b0, crc_seen);

    // ---- randomized frames against the model ----
    for (int n = 0; n < 40; n++) begin
      rand_pkt(p);
      send_frame(p, 1'(($urandom_range(0, 1))), $urandom_range(0, 40), -1,
                 1'(($urandom_range(0, 1))), crc_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
